// File: rtl/exe_stage_mc_pkg.sv
// rtl/exe_stage_mc_pkg.sv - shared encodings for the multi-cycle execute stage
package exe_stage_mc_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SRC_RF  = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_WB  = 2'd2;

    // Bit positions inside the 4-bit status word; carry sits at bit 2.
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exe_state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        return {v, c, z, n};
    endfunction

endpackage

// File: rtl/exe_stage_mc_mul_iter_unit.sv
// rtl/exe_stage_mc_mul_iter_unit.sv - iterative shift-add multiplier retiring MUL_BITS per cycle
module mul_iter_unit #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic              acc_en_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);
    localparam int LAT   = DATA_W / MUL_BITS;
    localparam int CNT_W = $clog2(LAT) + 1;

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic              last;

    function automatic logic [DATA_W-1:0] step_term(input logic [DATA_W-1:0] mc,
                                                    input logic [MUL_BITS-1:0] mp);
        logic [DATA_W-1:0] t;
        t = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mp[i]) t = t + (mc << i);
        end
        return t;
    endfunction

    // The first chunk is retired on the start edge and the final one is added
    // combinationally, so LAT chunks fit into LAT cycles counting the accept cycle.
    assign last      = busy_q && (cnt_q == CNT_W'(LAT - 1));
    assign busy_o    = busy_q;
    assign done_o    = last;
    assign product_o = acc_q + step_term(mcand_q, mplier_q[MUL_BITS-1:0]);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (busy_q) begin
            if (abort_i || last) begin
                busy_d = 1'b0;
            end else begin
                acc_d    = acc_q + step_term(mcand_q, mplier_q[MUL_BITS-1:0]);
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end else if (start_i && !abort_i) begin
            busy_d   = 1'b1;
            acc_d    = (acc_en_i ? acc_i : '0) + step_term(a_i, b_i[MUL_BITS-1:0]);
            mcand_d  = a_i << MUL_BITS;
            mplier_d = b_i >> MUL_BITS;
            cnt_d    = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - ARM execute stage with forwarding, Val2, ALU and iterative MUL/MLA
module exe_stage_mc
    import exe_stage_mc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              flush,
    input  logic              WB_en_in,
    input  logic              MEM_r_en_in,
    input  logic              MEM_w_en_in,
    input  logic              S_in,
    input  logic              imm,
    input  logic              branch_in,
    input  logic              mul_en,
    input  logic              acc_en,
    input  logic [1:0]        sel_src_1,
    input  logic [1:0]        sel_src_2,
    input  logic [3:0]        status,
    input  logic [3:0]        exec_cmd,
    input  logic [3:0]        dest_in,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       signed_immed_24,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DATA_W-1:0] val_rs,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] MEM_alu_res,
    input  logic [DATA_W-1:0] WB_value,
    output logic              stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_address,
    output logic              out_valid,
    output logic              WB_en_out,
    output logic              MEM_r_en_out,
    output logic              MEM_w_en_out,
    output logic              S_out,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        status_bits,
    output logic [3:0]        dest_out
);
    exe_state_e state_q, state_d;

    logic [DATA_W-1:0]   fwd_rn, fwd_rm, val2, imm8, alu_out, mul_prod, br_off;
    logic [2*DATA_W-1:0] ror_tmp;
    logic [DATA_W:0]     sum, cin_ext, one_ext;
    logic [4:0]          shamt;
    logic                c_out, v_out, accept, mul_busy, mul_done;
    logic                m_wb_q, m_s_q, m_c_q, m_v_q;
    logic [3:0]          m_dest_q;
    logic [DATA_W-1:0]   m_rm_q;

    function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel, input logic [DATA_W-1:0] rf,
                                              input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] wb);
        case (sel)
            SRC_MEM: return mem;
            SRC_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    assign fwd_rn  = fwd(sel_src_1, val_rn, MEM_alu_res, WB_value);
    assign fwd_rm  = fwd(sel_src_2, val_rm_in, MEM_alu_res, WB_value);
    assign imm8    = DATA_W'(shift_operand[7:0]);
    assign shamt   = shift_operand[11:7];
    assign cin_ext = {{DATA_W{1'b0}}, status[FLAG_C]};
    assign one_ext = {{DATA_W{1'b0}}, 1'b1};

    assign br_off         = {{(DATA_W-24){signed_immed_24[23]}}, signed_immed_24};
    assign branch_address = pc_in + (br_off << 2);
    assign branch_taken   = valid_in && branch_in && !flush && (state_q == ST_IDLE);

    assign accept = (state_q == ST_IDLE) && valid_in && mul_en && !flush;
    assign stall  = accept || ((state_q == ST_MUL) && mul_busy && !mul_done && !flush);

    always_comb begin
        ror_tmp = '0;
        val2    = fwd_rm;
        if (MEM_r_en_in || MEM_w_en_in) begin
            val2 = DATA_W'(shift_operand);
        end else if (imm) begin
            ror_tmp = {imm8, imm8} >> {shift_operand[11:8], 1'b0};
            val2    = ror_tmp[DATA_W-1:0];
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2 = fwd_rm << shamt;
                2'b01:   val2 = fwd_rm >> shamt;
                2'b10:   val2 = $signed(fwd_rm) >>> shamt;
                default: begin
                    ror_tmp = {fwd_rm, fwd_rm} >> shamt;
                    val2    = ror_tmp[DATA_W-1:0];
                end
            endcase
        end
    end

    // Logic ops and moves leave C and V at their incoming values.
    always_comb begin
        sum     = '0;
        alu_out = '0;
        c_out   = status[FLAG_C];
        v_out   = status[FLAG_V];
        case (exec_cmd)
            CMD_MOV: alu_out = val2;
            CMD_MVN: alu_out = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, fwd_rn} + {1'b0, val2} + ((exec_cmd == CMD_ADC) ? cin_ext : '0);
                alu_out = sum[DATA_W-1:0];
                c_out   = sum[DATA_W];
                v_out   = (fwd_rn[DATA_W-1] == val2[DATA_W-1]) && (alu_out[DATA_W-1] != fwd_rn[DATA_W-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum     = {1'b0, fwd_rn} + {1'b0, ~val2} + ((exec_cmd == CMD_SBC) ? cin_ext : one_ext);
                alu_out = sum[DATA_W-1:0];
                c_out   = sum[DATA_W];
                v_out   = (fwd_rn[DATA_W-1] != val2[DATA_W-1]) && (alu_out[DATA_W-1] != fwd_rn[DATA_W-1]);
            end
            CMD_AND: alu_out = fwd_rn & val2;
            CMD_ORR: alu_out = fwd_rn | val2;
            CMD_EOR: alu_out = fwd_rn ^ val2;
            default: alu_out = '0;
        endcase
    end

    mul_iter_unit #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept),
        .abort_i   (flush),
        .a_i       (fwd_rm),
        .b_i       (val_rs),
        .acc_i     (fwd_rn),
        .acc_en_i  (acc_en),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_MUL;
            ST_MUL:  if (flush || mul_done || !mul_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            m_wb_q   <= 1'b0;
            m_s_q    <= 1'b0;
            m_c_q    <= 1'b0;
            m_v_q    <= 1'b0;
            m_dest_q <= '0;
            m_rm_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                m_wb_q   <= WB_en_in;
                m_s_q    <= S_in;
                m_c_q    <= status[FLAG_C];
                m_v_q    <= status[FLAG_V];
                m_dest_q <= dest_in;
                m_rm_q   <= fwd_rm;
            end
        end
    end

    // EXE/MEM register: MUL result, single-cycle result, or an all-zero bubble.
    always_ff @(posedge clk) begin
        out_valid    <= 1'b0;
        WB_en_out    <= 1'b0;
        MEM_r_en_out <= 1'b0;
        MEM_w_en_out <= 1'b0;
        S_out        <= 1'b0;
        alu_res      <= '0;
        val_rm_out   <= '0;
        status_bits  <= '0;
        dest_out     <= '0;
        if (!rst) begin
            if ((state_q == ST_MUL) && mul_done && !flush) begin
                out_valid   <= 1'b1;
                WB_en_out   <= m_wb_q;
                S_out       <= m_s_q;
                alu_res     <= mul_prod;
                val_rm_out  <= m_rm_q;
                status_bits <= pack_flags(mul_prod[DATA_W-1], mul_prod == '0, m_c_q, m_v_q);
                dest_out    <= m_dest_q;
            end else if ((state_q == ST_IDLE) && valid_in && !flush && !mul_en) begin
                out_valid    <= 1'b1;
                WB_en_out    <= WB_en_in;
                MEM_r_en_out <= MEM_r_en_in;
                MEM_w_en_out <= MEM_w_en_in;
                S_out        <= S_in;
                alu_res      <= alu_out;
                val_rm_out   <= fwd_rm;
                status_bits  <= pack_flags(alu_out[DATA_W-1], alu_out == '0, c_out, v_out);
                dest_out     <= dest_in;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - directed vector bench for exe_stage_mc
module tb_exe_stage_mc;
    import exe_stage_mc_pkg::*;

    logic        clk, rst, valid_in, flush, WB_en_in, MEM_r_en_in, MEM_w_en_in, S_in, imm, branch_in;
    logic        mul_en, acc_en;
    logic [1:0]  sel_src_1, sel_src_2;
    logic [3:0]  status, exec_cmd, dest_in;
    logic [11:0] shift_operand;
    logic [23:0] signed_immed_24;
    logic [31:0] val_rn, val_rm_in, val_rs, pc_in, MEM_alu_res, WB_value;
    logic        stall, branch_taken, out_valid, WB_en_out, MEM_r_en_out, MEM_w_en_out, S_out;
    logic [31:0] branch_address, alu_res, val_rm_out;
    logic [3:0]  status_bits, dest_out;

    int n_pass = 0;
    int n_total = 0;

    exe_stage_mc #(.DATA_W(32), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .WB_en_in(WB_en_in),
        .MEM_r_en_in(MEM_r_en_in), .MEM_w_en_in(MEM_w_en_in), .S_in(S_in), .imm(imm),
        .branch_in(branch_in), .mul_en(mul_en), .acc_en(acc_en), .sel_src_1(sel_src_1),
        .sel_src_2(sel_src_2), .status(status), .exec_cmd(exec_cmd), .dest_in(dest_in),
        .shift_operand(shift_operand), .signed_immed_24(signed_immed_24), .val_rn(val_rn),
        .val_rm_in(val_rm_in), .val_rs(val_rs), .pc_in(pc_in), .MEM_alu_res(MEM_alu_res),
        .WB_value(WB_value), .stall(stall), .branch_taken(branch_taken),
        .branch_address(branch_address), .out_valid(out_valid), .WB_en_out(WB_en_out),
        .MEM_r_en_out(MEM_r_en_out), .MEM_w_en_out(MEM_w_en_out), .S_out(S_out),
        .alu_res(alu_res), .val_rm_out(val_rm_out), .status_bits(status_bits), .dest_out(dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, flush, imm, mr, mw;
        logic [3:0]  cmd, status;
        logic [1:0]  s1, s2;
        logic [11:0] sop;
        logic [31:0] rn, rm;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic [31:0] exp_rm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic valid, input logic fl, input logic [3:0] cmd,
                                input logic im, input logic mr, input logic mw,
                                input logic [1:0] s1, input logic [1:0] s2, input logic [11:0] sop,
                                input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] st,
                                input logic [31:0] er, input logic [3:0] ef, input logic [31:0] erm);
        vec_t v;
        v.valid = valid; v.flush = fl; v.cmd = cmd; v.imm = im; v.mr = mr; v.mw = mw;
        v.s1 = s1; v.s2 = s2; v.sop = sop; v.rn = rn; v.rm = rm; v.status = st;
        v.exp_res = er; v.exp_flags = ef; v.exp_rm = erm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        valid_in = 0; flush = 0; WB_en_in = 0; MEM_r_en_in = 0; MEM_w_en_in = 0; S_in = 0;
        imm = 0; branch_in = 0; mul_en = 0; acc_en = 0; sel_src_1 = SRC_RF; sel_src_2 = SRC_RF;
        status = 0; exec_cmd = 0; dest_in = 0; shift_operand = 0; signed_immed_24 = 0;
        val_rn = 0; val_rm_in = 0; val_rs = 0; pc_in = 0; MEM_alu_res = 100; WB_value = 32'h0F;
    endtask

    // Inputs for the MUL are driven just before this; operand sources are
    // disturbed after accept to show they were captured.
    task automatic run_mul(output int stall_cyc, output int lat);
        stall_cyc = 0;
        lat = 0;
        while (lat < 100) begin
            #1;
            if (stall) stall_cyc++;
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
            if (lat == 1) begin
                val_rm_in = 99; val_rn = 777; WB_value = 500; MEM_alu_res = 600; val_rs = 3; status = 0;
            end
            @(negedge clk);
        end
        valid_in = 0; mul_en = 0; acc_en = 0;
    endtask

    initial begin
        int sc, lat, hits;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset alu_res", alu_res, 0);
        check("reset status_bits", status_bits, 0);
        check("reset stall", stall, 0);
        @(negedge clk);
        rst = 0;

        vecs.push_back(mk(1,0,CMD_ADD,0,0,0,SRC_MEM,SRC_RF,12'h000,5,3,4'b0000, 103,4'b0000,3));
        vecs.push_back(mk(1,0,CMD_SUB,0,0,0,SRC_RF,SRC_RF,12'h000,5,5,4'b0000, 0,4'b0110,5));
        vecs.push_back(mk(1,0,CMD_SUB,0,0,0,SRC_RF,SRC_RF,12'h000,3,5,4'b0000, 32'hFFFFFFFE,4'b0001,5));
        vecs.push_back(mk(1,0,CMD_ADD,0,0,0,SRC_RF,SRC_RF,12'h000,32'h7FFFFFFF,1,4'b0000, 32'h80000000,4'b1001,1));
        vecs.push_back(mk(1,0,CMD_ADD,0,0,0,SRC_RF,SRC_RF,12'h000,32'hFFFFFFFF,1,4'b0000, 0,4'b0110,1));
        vecs.push_back(mk(1,0,CMD_ADC,0,0,0,SRC_RF,SRC_RF,12'h000,1,1,4'b0100, 3,4'b0000,1));
        vecs.push_back(mk(1,0,CMD_MOV,1,0,0,SRC_RF,SRC_RF,12'h4FF,0,0,4'b0000, 32'hFF000000,4'b0001,0));
        vecs.push_back(mk(1,0,CMD_MVN,0,0,0,SRC_RF,SRC_RF,12'h000,0,0,4'b1100, 32'hFFFFFFFF,4'b1101,0));
        vecs.push_back(mk(1,0,CMD_AND,0,0,0,SRC_RF,SRC_RF,12'h000,32'hF0F0,32'hFF00,4'b0000, 32'hF000,4'b0000,32'hFF00));
        vecs.push_back(mk(1,0,CMD_ORR,0,0,0,SRC_RF,SRC_WB,12'h000,32'hF0,32'h12345,4'b0000, 32'hFF,4'b0000,32'h0F));
        vecs.push_back(mk(1,0,CMD_EOR,0,0,0,SRC_RF,SRC_RF,12'h000,32'hFF,32'h0F,4'b0000, 32'hF0,4'b0000,32'h0F));
        vecs.push_back(mk(1,0,CMD_MOV,0,0,0,SRC_RF,SRC_RF,12'h200,0,1,4'b0000, 16,4'b0000,1));
        vecs.push_back(mk(1,0,CMD_MOV,0,0,0,SRC_RF,SRC_RF,12'h240,0,32'h80000000,4'b0000, 32'hF8000000,4'b0001,32'h80000000));
        vecs.push_back(mk(1,0,CMD_MOV,0,0,0,SRC_RF,SRC_RF,12'h460,0,32'hAB,4'b0000, 32'hAB000000,4'b0001,32'hAB));
        vecs.push_back(mk(1,0,CMD_ADD,0,0,1,SRC_RF,SRC_RF,12'hFFC,32'h1000,32'hAB,4'b0000, 32'h1FFC,4'b0000,32'hAB));
        vecs.push_back(mk(1,0,CMD_ADD,1,1,0,SRC_RF,SRC_RF,12'h4FF,0,0,4'b0000, 32'h4FF,4'b0000,0));
        vecs.push_back(mk(0,0,CMD_ADD,0,0,0,SRC_RF,SRC_RF,12'h000,1,1,4'b0000, 0,4'b0000,0));
        vecs.push_back(mk(1,1,CMD_ADD,0,0,0,SRC_RF,SRC_RF,12'h000,1,1,4'b0000, 0,4'b0000,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid_in = vecs[i].valid; flush = vecs[i].flush; exec_cmd = vecs[i].cmd;
            imm = vecs[i].imm; MEM_r_en_in = vecs[i].mr; MEM_w_en_in = vecs[i].mw;
            sel_src_1 = vecs[i].s1; sel_src_2 = vecs[i].s2; shift_operand = vecs[i].sop;
            val_rn = vecs[i].rn; val_rm_in = vecs[i].rm; status = vecs[i].status;
            dest_in = 4'(i); WB_en_in = 1;
            #1;
            check($sformatf("vec%0d stall", i), stall, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].valid & !vecs[i].flush);
            check($sformatf("vec%0d alu_res", i), alu_res, vecs[i].exp_res);
            check($sformatf("vec%0d status_bits", i), status_bits, vecs[i].exp_flags);
            check($sformatf("vec%0d val_rm_out", i), val_rm_out, vecs[i].exp_rm);
            check($sformatf("vec%0d dest_out", i), dest_out,
                  (vecs[i].valid & !vecs[i].flush) ? 32'(i) : 0);
        end

        // MUL 7*6 with C,V set in the latched status
        @(negedge clk);
        idle_inputs();
        valid_in = 1; mul_en = 1; WB_en_in = 1; val_rm_in = 7; val_rs = 6; status = 4'b1100; dest_in = 4'd9;
        run_mul(sc, lat);
        check("mul stall cycles", sc, 31);
        check("mul latency", lat, 32);
        check("mul alu_res", alu_res, 42);
        check("mul status_bits", status_bits, 4'b1100);
        check("mul val_rm_out", val_rm_out, 7);
        check("mul dest_out", dest_out, 9);
        check("mul WB_en_out", WB_en_out, 1);
        @(negedge clk);
        #1;
        check("after mul stall", stall, 0);

        // MLA with Rn forwarded from WB
        idle_inputs();
        valid_in = 1; mul_en = 1; acc_en = 1; val_rm_in = 32'hFFFFFFFF; val_rs = 2;
        val_rn = 55; sel_src_1 = SRC_WB; WB_value = 1; status = 4'b1000; dest_in = 4'd3;
        run_mul(sc, lat);
        check("mla latency", lat, 32);
        check("mla alu_res", alu_res, 32'hFFFFFFFF);
        check("mla status_bits", status_bits, 4'b1001);

        // Flush during MUL
        @(negedge clk);
        idle_inputs();
        valid_in = 1; mul_en = 1; val_rm_in = 5; val_rs = 5;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        check("flush pre stall", stall, 1);
        flush = 1;
        #1;
        check("flush stall drop", stall, 0);
        @(posedge clk);
        #1;
        check("flush bubble", out_valid, 0);
        @(negedge clk);
        idle_inputs();
        valid_in = 1; exec_cmd = CMD_ADD; val_rn = 2; val_rm_in = 3;
        #1;
        check("post flush stall", stall, 0);
        @(posedge clk);
        #1;
        check("post flush valid", out_valid, 1);
        check("post flush alu_res", alu_res, 5);

        // Reset mid-MUL
        @(negedge clk);
        idle_inputs();
        valid_in = 1; mul_en = 1; val_rm_in = 11; val_rs = 13;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1; valid_in = 0; mul_en = 0;
        @(posedge clk);
        #1;
        check("rst mul out_valid", out_valid, 0);
        check("rst mul alu_res", alu_res, 0);
        check("rst mul dest_out", dest_out, 0);
        check("rst mul stall", stall, 0);
        @(negedge clk);
        rst = 0;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || stall) hits++;
        end
        check("rst no late result", hits, 0);

        // Branch
        @(negedge clk);
        idle_inputs();
        valid_in = 1; branch_in = 1; pc_in = 32'h100; signed_immed_24 = 24'hFFFFFE;
        #1;
        check("branch taken", branch_taken, 1);
        check("branch address", branch_address, 32'hF8);
        flush = 1;
        #1;
        check("branch flushed", branch_taken, 0);
        @(negedge clk);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
